// File: rtl/egress_pkg.sv
// Shared types and helpers for the byte egress serializer.
package egress_pkg;

  localparam int DefWordW = 32;
  localparam int DefByteW = 8;

  typedef enum logic {IDLE, SEND} serState_e;

  function automatic int bytes_per_word(input int wordW, input int byteW);
    return wordW / byteW;
  endfunction

endpackage

// File: rtl/egress_word_fifo.sv
// DEPTH x WORD_W word FIFO; full/empty come from the occupancy count, pointers wrap freely.
module egress_word_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  localparam int PtrW  = $clog2(DEPTH),
  localparam int LvlW  = $clog2(DEPTH) + 1
) (
  input  logic              ClkEngress,
  input  logic              ARst,
  input  logic              Push,
  input  logic [WORD_W-1:0] PushData,
  input  logic              Pop,
  output logic [WORD_W-1:0] HeadData,
  output logic [LvlW-1:0]   Level,
  output logic              Full,
  output logic              Empty
);

  logic [DEPTH-1:0][WORD_W-1:0] mem;
  logic [PtrW-1:0]              wrPtr, rdPtr;
  logic                         doPush, doPop;

  assign Full     = (Level == LvlW'(DEPTH));
  assign Empty    = (Level == '0);
  assign doPush   = Push && !Full;
  assign doPop    = Pop && !Empty;
  assign HeadData = mem[rdPtr];

  // Storage carries no reset; only the pointers and count define content.
  always_ff @(posedge ClkEngress) begin
    if (doPush) mem[wrPtr] <= PushData;
  end

  always_ff @(posedge ClkEngress or posedge ARst) begin
    if (ARst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)  rdPtr <= rdPtr + PtrW'(1);
      case ({doPush, doPop})
        2'b10:   Level <= Level + LvlW'(1);
        2'b01:   Level <= Level - LvlW'(1);
        default: Level <= Level;
      endcase
    end
  end

endmodule

// File: rtl/byte_egress_fifo.sv
// Word-to-byte egress serializer: buffers words in a FIFO and emits one registered byte
// per clock under ready/valid flow control, with a sticky overflow flag.
module byte_egress_fifo
  import egress_pkg::*;
#(
  parameter int WORD_W    = DefWordW,
  parameter int BYTE_W    = DefByteW,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int LvlW     = $clog2(DEPTH) + 1
) (
  input  logic              ClkEngress,
  input  logic              ARst,
  input  logic [WORD_W-1:0] WriteData,
  input  logic              WriteDataValid,
  output logic              WriteReady,
  output logic [BYTE_W-1:0] Data,
  output logic              DataValid,
  input  logic              DataReady,
  output logic [LvlW-1:0]   Level,
  output logic              Overflow,
  input  logic              ClrOverflow
);

  localparam int BYTES = bytes_per_word(WORD_W, BYTE_W);
  localparam int IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);

  if (WORD_W % BYTE_W != 0) begin : gErrWidth
    $error("byte_egress_fifo: WORD_W must be a multiple of BYTE_W");
  end
  if (BYTES < 2) begin : gErrBytes
    $error("byte_egress_fifo: a word must hold at least two bytes");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gErrDepth
    $error("byte_egress_fifo: DEPTH must be a power of two >= 2");
  end

  serState_e         state, stateNxt;
  logic [WORD_W-1:0] wordReg, wordNxt, headWord;
  logic [IdxW-1:0]   byteIdx, idxNxt, idxInc;
  logic [BYTE_W-1:0] dataNxt;
  logic              dvNxt, push, pop, fifoFull, fifoEmpty;

  function automatic logic [BYTE_W-1:0] pickByte(input logic [WORD_W-1:0] w,
                                                 input logic [IdxW-1:0]   k);
    logic [BYTES-1:0][BYTE_W-1:0] wb;
    logic [IdxW-1:0]              sel;
    wb  = w;
    sel = MSB_FIRST ? (LastIdx - k) : k;
    return wb[sel];
  endfunction

  assign WriteReady = !fifoFull;
  assign push       = WriteDataValid && WriteReady;
  assign idxInc     = byteIdx + IdxW'(1);

  egress_word_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) uFifo (
    .ClkEngress (ClkEngress),
    .ARst       (ARst),
    .Push       (push),
    .PushData   (WriteData),
    .Pop        (pop),
    .HeadData   (headWord),
    .Level      (Level),
    .Full       (fifoFull),
    .Empty      (fifoEmpty)
  );

  // A freshly loaded word spends one cycle in SEND with DataValid low before byte 0 shows;
  // back-to-back words skip that step and load byte 0 straight from the FIFO head.
  always_comb begin
    stateNxt = state;
    wordNxt  = wordReg;
    idxNxt   = byteIdx;
    dataNxt  = Data;
    dvNxt    = DataValid;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop      = 1'b1;
          wordNxt  = headWord;
          idxNxt   = '0;
          stateNxt = SEND;
        end
      end
      SEND: begin
        if (!DataValid) begin
          dataNxt = pickByte(wordReg, '0);
          dvNxt   = 1'b1;
        end else if (DataReady) begin
          if (byteIdx != LastIdx) begin
            idxNxt  = idxInc;
            dataNxt = pickByte(wordReg, idxInc);
          end else if (!fifoEmpty) begin
            pop     = 1'b1;
            wordNxt = headWord;
            idxNxt  = '0;
            dataNxt = pickByte(headWord, '0);
          end else begin
            idxNxt   = '0;
            dvNxt    = 1'b0;
            stateNxt = IDLE;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge ClkEngress or posedge ARst) begin
    if (ARst) begin
      state     <= IDLE;
      wordReg   <= '0;
      byteIdx   <= '0;
      Data      <= '0;
      DataValid <= 1'b0;
    end else begin
      state     <= stateNxt;
      wordReg   <= wordNxt;
      byteIdx   <= idxNxt;
      Data      <= dataNxt;
      DataValid <= dvNxt;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge ClkEngress or posedge ARst) begin
    if (ARst)                              Overflow <= 1'b0;
    else if (WriteDataValid && !WriteReady) Overflow <= 1'b1;
    else if (ClrOverflow)                  Overflow <= 1'b0;
  end

endmodule

// File: tb/tb_byte_egress_fifo.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) share all stimulus.
module tb_byte_egress_fifo;

  logic        ClkEngress = 1'b0;
  logic        ARst = 1'b1;
  logic [31:0] WriteData = '0;
  logic        WriteDataValid = 1'b0;
  logic        DataReady = 1'b0;
  logic        ClrOverflow = 1'b0;

  logic        wr0, wr1, dv0, dv1, ov0, ov1;
  logic [7:0]  d0, d1;
  logic [2:0]  lvl0, lvl1;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          total = 0, bad = 0;
  logic        st0 = 1'b0, st1 = 1'b0;
  logic [7:0]  h0 = '0, h1 = '0;
  logic        gapChk = 1'b0, sawV = 1'b0, sawFull = 1'b0;
  int          gaps = 0, quietCnt = 0;
  logic        quiet = 1'b0;

  always #5 ClkEngress = ~ClkEngress;

  byte_egress_fifo #(.WORD_W(32), .BYTE_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) uLsb (
    .ClkEngress(ClkEngress), .ARst(ARst), .WriteData(WriteData),
    .WriteDataValid(WriteDataValid), .WriteReady(wr0), .Data(d0), .DataValid(dv0),
    .DataReady(DataReady), .Level(lvl0), .Overflow(ov0), .ClrOverflow(ClrOverflow));

  byte_egress_fifo #(.WORD_W(32), .BYTE_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) uMsb (
    .ClkEngress(ClkEngress), .ARst(ARst), .WriteData(WriteData),
    .WriteDataValid(WriteDataValid), .WriteReady(wr1), .Data(d1), .DataValid(dv1),
    .DataReady(DataReady), .Level(lvl1), .Overflow(ov1), .ClrOverflow(ClrOverflow));

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic failNow(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic expectWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      q0.push_back(w[k*8 +: 8]);
      q1.push_back(w[(3-k)*8 +: 8]);
    end
  endtask

  task automatic tick();
    @(posedge ClkEngress);
    #1;
  endtask

  // Waits for room so no overflow is provoked, then presents the word for one cycle.
  task automatic wr(input logic [31:0] w);
    int n;
    n = 0;
    WriteDataValid = 1'b0;
    while (!wr0 && n < 200) begin
      tick();
      n++;
    end
    if (!wr0) failNow("write ready timeout");
    WriteData = w;
    WriteDataValid = 1'b1;
    expectWord(w);
    tick();
    WriteDataValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || dv0 || dv1) && n < 300) begin
      tick();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0 || dv0 || dv1) failNow("drain timeout");
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!dv0 && n < 50) begin
      tick();
      n++;
    end
    if (!dv0) failNow("data valid timeout");
  endtask

  // Monitor: pops expected bytes on every consume, checks stability under stall.
  always @(negedge ClkEngress) begin
    if (ARst) begin
      st0 = 1'b0;
      st1 = 1'b0;
    end else begin
      if (st0) cmp("lsb hold", 32'({dv0, d0}), 32'({1'b1, h0}));
      if (st1) cmp("msb hold", 32'({dv1, d1}), 32'({1'b1, h1}));
      if (dv0 && DataReady) begin
        if (q0.size() == 0) failNow($sformatf("lsb unexpected byte %0h", d0));
        else cmp("lsb byte", 32'(d0), 32'(q0.pop_front()));
      end
      if (dv1 && DataReady) begin
        if (q1.size() == 0) failNow($sformatf("msb unexpected byte %0h", d1));
        else cmp("msb byte", 32'(d1), 32'(q1.pop_front()));
      end
      st0 = dv0 && !DataReady;
      st1 = dv1 && !DataReady;
      h0  = d0;
      h1  = d1;
      if (lvl0 == 3'd4) cmp("ready low at full", 32'(wr0), 0);
      if (gapChk) begin
        if (dv0) sawV = 1'b1;
        if (sawV && !dv0 && q0.size() != 0) gaps++;
        if (lvl0 == 3'd4) sawFull = 1'b1;
      end
      if (quiet && (dv0 || dv1)) quietCnt++;
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    cmp("rst Data", 32'(d0), 0);
    cmp("rst DataValid", 32'(dv0), 0);
    cmp("rst Level", 32'(lvl0), 0);
    cmp("rst Overflow", 32'(ov0), 0);
    cmp("rst WriteReady", 32'(wr0), 1);
    cmp("rst msb DataValid", 32'(dv1), 0);
    ARst = 1'b0;
    tick();

    // 1/2: single word, latency and both byte orders
    DataReady = 1'b1;
    wr(32'hA1B2C3D4);
    cmp("t1 dv at N", 32'(dv0), 0);
    tick();
    cmp("t1 dv at N+1", 32'(dv0), 0);
    tick();
    cmp("t1 dv at N+2", 32'(dv0), 1);
    cmp("t1 lsb first byte", 32'(d0), 32'hD4);
    cmp("t2 msb first byte", 32'(d1), 32'hA1);
    waitIdle();

    // 3: sustained stream of 8 words
    gapChk = 1'b1;
    sawV = 1'b0;
    sawFull = 1'b0;
    gaps = 0;
    for (int i = 0; i < 8; i++) wr(32'h10203040 + 32'(i * 32'h01010101));
    waitIdle();
    gapChk = 1'b0;
    cmp("t3 valid gaps", 32'(gaps), 0);
    cmp("t3 reached full", 32'(sawFull), 1);
    cmp("t3 overflow", 32'(ov0), 0);

    // 4: backpressure in the middle of byte 1
    DataReady = 1'b0;
    wr(32'h11223344);
    waitValid();
    DataReady = 1'b1;
    tick();
    DataReady = 1'b0;
    cmp("t4 lsb byte1", 32'(d0), 32'h33);
    cmp("t4 msb byte1", 32'(d1), 32'h22);
    repeat (5) tick();
    cmp("t4 lsb byte1 held", 32'({dv0, d0}), 32'h133);
    DataReady = 1'b1;
    waitIdle();

    // 5: overflow, clear, and set-beats-clear
    DataReady = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'hC0000000 + 32'(i));
    cmp("t5 level full", 32'(lvl0), 4);
    cmp("t5 ready low", 32'(wr0), 0);
    cmp("t5 no overflow yet", 32'(ov0), 0);
    WriteData = 32'hDEADBEEF;
    WriteDataValid = 1'b1;
    tick();
    WriteDataValid = 1'b0;
    cmp("t5 overflow set", 32'(ov0), 1);
    cmp("t5 level after drop", 32'(lvl0), 4);
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    cmp("t5 overflow cleared", 32'(ov0), 0);
    WriteDataValid = 1'b1;
    ClrOverflow = 1'b1;
    tick();
    WriteDataValid = 1'b0;
    ClrOverflow = 1'b0;
    cmp("t5 set wins over clear", 32'(ov0), 1);
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    cmp("t5 overflow cleared again", 32'(ov0), 0);
    DataReady = 1'b1;
    waitIdle();

    // 6: reset after byte 1 with two words queued
    DataReady = 1'b0;
    wr(32'h55667788);
    wr(32'h99AABBCC);
    wr(32'hDDEEFF00);
    waitValid();
    DataReady = 1'b1;
    tick();
    tick();
    DataReady = 1'b0;
    ARst = 1'b1;
    #1;
    cmp("t6 rst DataValid", 32'(dv0), 0);
    cmp("t6 rst Level", 32'(lvl0), 0);
    cmp("t6 rst WriteReady", 32'(wr0), 1);
    cmp("t6 rst msb DataValid", 32'(dv1), 0);
    q0.delete();
    q1.delete();
    tick();
    ARst = 1'b0;
    DataReady = 1'b1;
    quiet = 1'b1;
    repeat (20) tick();
    quiet = 1'b0;
    cmp("t6 bytes after reset", 32'(quietCnt), 0);
    wr(32'h0BADF00D);
    waitIdle();
    cmp("scoreboard empty", 32'(q0.size() + q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
